jt08_adpcm_gain_mc: RTL and testbench



---
 rtl/jt08_adpcm_pkg.sv | 19 +
 rtl/jt08_adpcm_gain_ramp.sv | 52 +++++
 rtl/jt08_adpcm_gain_mc.sv | 140 ++++++++++++++
 tb/tb_jt08_adpcm_gain_mc.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/jt08_adpcm_pkg.sv
// jt08_adpcm_pkg: shared constants, channel register layout and target-attenuation helper
package jt08_adpcm_pkg;
    localparam int MODE_MAME = 0;
    localparam int MODE_LLE  = 1;
    localparam int DB_W      = 7;
    localparam logic [DB_W-1:0] MUTE_DB = 7'h7F;
    localparam int UP_LR_LSB = 6;
    localparam int UP_IL_LSB = 0;
    localparam int IL_W      = 5;

    typedef struct packed {
        logic [1:0]      lr;
        logic [IL_W-1:0] il;
    } ch_reg_t;

    function automatic logic [DB_W-1:0] tgt_db(input logic [IL_W-1:0] il, input logic [5:0] atl);
        return {2'b0, ~il} + {1'b0, ~atl};
    endfunction
endpackage

// File: rtl/jt08_adpcm_gain_ramp.sv
// jt08_adpcm_gain_ramp: per-channel level/pan registers and applied attenuation with optional ramping
module jt08_adpcm_gain_ramp
    import jt08_adpcm_pkg::*;
#(
    parameter int CH   = 6,
    parameter int RAMP = 0,
    parameter int CW   = 3
)(
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      atl,
    input  logic            up_en,
    input  logic [CW-1:0]   up_ch,
    input  logic [7:0]      up_data,
    input  logic            acc_en,
    input  logic [CW-1:0]   acc_ch,
    output logic [DB_W-1:0] db,
    output logic [1:0]      lr
);
    ch_reg_t         r_reg [CH];
    logic [DB_W-1:0] r_cur [CH];
    logic            w_up_ok;
    logic [CW-1:0]   w_sel;
    logic [DB_W-1:0] w_tgt;
    logic [DB_W-1:0] w_cur;
    logic [DB_W-1:0] w_next;

    assign w_up_ok = up_en && ({1'b0, up_ch} < (CW+1)'(CH));
    assign w_sel   = ({1'b0, acc_ch} < (CW+1)'(CH)) ? acc_ch : '0;
    assign w_tgt   = tgt_db(r_reg[w_sel].il, atl);
    assign w_cur   = r_cur[w_sel];
    // ramping moves one unit per accepted sample of this channel
    assign w_next  = (RAMP == 0)    ? w_tgt :
                     (w_cur < w_tgt) ? w_cur + 7'd1 :
                     (w_cur > w_tgt) ? w_cur - 7'd1 : w_cur;
    assign db = w_next;
    assign lr = r_reg[w_sel].lr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                r_reg[i] <= '0;
                r_cur[i] <= MUTE_DB;
            end
        end else begin
            if (w_up_ok)
                r_reg[up_ch] <= '{lr: up_data[UP_LR_LSB+:2], il: up_data[UP_IL_LSB+:IL_W]};
            if (acc_en)
                r_cur[w_sel] <= w_next;
        end
    end
endmodule

// File: rtl/jt08_adpcm_gain_mc.sv
// jt08_adpcm_gain_mc: multi-channel ADPCM gain stage, 4-stage pipeline
// with MAME multiply/shift or LLE add/shift gain formulas.
module jt08_adpcm_gain_mc
    import jt08_adpcm_pkg::*;
#(
    parameter int CH   = 6,
    parameter int DW   = 16,
    parameter int MODE = MODE_MAME,
    parameter int RAMP = 0,
    parameter int MASK = 2,
    localparam int CW  = (CH > 1) ? $clog2(CH) : 1
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cen,
    input  logic [5:0]           atl,
    input  logic                 up_en,
    input  logic [CW-1:0]        up_ch,
    input  logic [7:0]           up_data,
    input  logic                 in_valid,
    input  logic [CW-1:0]        in_ch,
    input  logic signed [DW-1:0] pcm_in,
    output logic                 out_valid,
    output logic [CW-1:0]        out_ch,
    output logic [1:0]           lr,
    output logic signed [DW-1:0] pcm_att
);
    localparam int PW = DW + 4;

    logic                 w_in_ok;
    logic                 w_acc;
    logic [DB_W-1:0]      w_db;
    logic [1:0]           w_lr;

    logic                 r1_v;
    logic signed [DW-1:0] r1_pcm;
    logic [CW-1:0]        r1_ch;
    logic [1:0]           r1_lr;
    logic [DB_W-1:0]      r1_db;

    logic                 r2_v;
    logic signed [PW-1:0] r2_val;
    logic [3:0]           r2_sh;
    logic [CW-1:0]        r2_ch;
    logic [1:0]           r2_lr;

    logic                 r3_v;
    logic signed [PW-1:0] r3_val;
    logic [CW-1:0]        r3_ch;
    logic [1:0]           r3_lr;

    logic signed [PW-1:0] w_pcm_x, w_lin_x, w_mame;
    logic signed [PW-1:0] w_s1, w_s2, w_s3, w_h1, w_h2, w_h3, w_lle;
    logic signed [PW-1:0] w_val, w_asr, w_shr;
    logic [3:0]           w_lin, w_sh;
    logic [PW-DW:0]       w_hi;
    logic [DW-1:0]        w_sat, w_msk;

    assign w_in_ok = {1'b0, in_ch} < (CW+1)'(CH);
    assign w_acc   = cen && in_valid && w_in_ok;

    jt08_adpcm_gain_ramp #(.CH(CH), .RAMP(RAMP), .CW(CW)) u_ramp (
        .clk     (clk),
        .rst     (rst),
        .atl     (atl),
        .up_en   (up_en),
        .up_ch   (up_ch),
        .up_data (up_data),
        .acc_en  (w_acc),
        .acc_ch  (in_ch),
        .db      (w_db),
        .lr      (w_lr)
    );

    assign w_pcm_x = PW'(r1_pcm);
    assign w_lin   = r1_db[6] ? 4'd0 : 4'd15 - {1'b0, r1_db[2:0]};
    assign w_lin_x = PW'({1'b0, w_lin});
    assign w_mame  = w_pcm_x * w_lin_x;
    // shifted terms kept in their own signed nets so >>> stays arithmetic
    assign w_s1    = w_pcm_x >>> 1;
    assign w_s2    = w_pcm_x >>> 2;
    assign w_s3    = w_pcm_x >>> 3;
    assign w_h1    = r1_db[2] ? '0 : w_s1;
    assign w_h2    = r1_db[1] ? '0 : w_s2;
    assign w_h3    = r1_db[0] ? '0 : w_s3;
    assign w_lle   = w_pcm_x + w_h1 + w_h2 + w_h3;
    assign w_val   = (MODE == MODE_LLE) ? w_lle : w_mame;
    assign w_sh    = (MODE == MODE_LLE) ? r1_db[6:3] : {1'b0, r1_db[5:3]} + 4'd1;

    assign w_asr   = r2_val >>> r2_sh;
    assign w_shr   = (32'(r2_sh) >= DW) ? {PW{r2_val[PW-1]}} : w_asr;

    assign w_hi    = r3_val[PW-1:DW-1];
    assign w_sat   = (&w_hi || ~|w_hi) ? r3_val[DW-1:0] : {r3_val[PW-1], {(DW-1){~r3_val[PW-1]}}};
    assign w_msk   = ~((DW'(1) << MASK) - DW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_v      <= 1'b0;
            r1_pcm    <= '0;
            r1_ch     <= '0;
            r1_lr     <= '0;
            r1_db     <= '0;
            r2_v      <= 1'b0;
            r2_val    <= '0;
            r2_sh     <= '0;
            r2_ch     <= '0;
            r2_lr     <= '0;
            r3_v      <= 1'b0;
            r3_val    <= '0;
            r3_ch     <= '0;
            r3_lr     <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            lr        <= '0;
            pcm_att   <= '0;
        end else if (cen) begin
            r1_v   <= in_valid && w_in_ok;
            r1_pcm <= pcm_in;
            r1_ch  <= in_ch;
            r1_lr  <= w_lr;
            r1_db  <= w_db;
            r2_v   <= r1_v;
            r2_val <= w_val;
            r2_sh  <= w_sh;
            r2_ch  <= r1_ch;
            r2_lr  <= r1_lr;
            r3_v   <= r2_v;
            r3_val <= w_shr;
            r3_ch  <= r2_ch;
            r3_lr  <= r2_lr;
            out_valid <= r3_v;
            if (r3_v) begin
                out_ch  <= r3_ch;
                lr      <= r3_lr;
                pcm_att <= w_sat & w_msk;
            end
        end
    end
endmodule

// File: tb/tb_jt08_adpcm_gain_mc.sv
// tb_jt08_adpcm_gain_mc: directed vectors over MAME, LLE and ramping instances
module tb_jt08_adpcm_gain_mc;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst, cen, up_en, in_valid;
    logic [5:0] atl;
    logic [CW-1:0] up_ch, in_ch;
    logic [7:0] up_data;
    logic signed [15:0] pcm_in;

    logic ov0, ov1, ov2;
    logic [CW-1:0] oc0, oc1, oc2;
    logic [1:0] lr0, lr1, lr2;
    logic signed [15:0] pa0, pa1, pa2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jt08_adpcm_gain_mc #(.CH(6), .DW(16), .MODE(0), .RAMP(0), .MASK(2)) u_mame (
        .clk(clk), .rst(rst), .cen(cen), .atl(atl), .up_en(up_en), .up_ch(up_ch),
        .up_data(up_data), .in_valid(in_valid), .in_ch(in_ch), .pcm_in(pcm_in),
        .out_valid(ov0), .out_ch(oc0), .lr(lr0), .pcm_att(pa0));

    jt08_adpcm_gain_mc #(.CH(6), .DW(16), .MODE(1), .RAMP(0), .MASK(2)) u_lle (
        .clk(clk), .rst(rst), .cen(cen), .atl(atl), .up_en(up_en), .up_ch(up_ch),
        .up_data(up_data), .in_valid(in_valid), .in_ch(in_ch), .pcm_in(pcm_in),
        .out_valid(ov1), .out_ch(oc1), .lr(lr1), .pcm_att(pa1));

    jt08_adpcm_gain_mc #(.CH(6), .DW(16), .MODE(0), .RAMP(1), .MASK(2)) u_ramp (
        .clk(clk), .rst(rst), .cen(cen), .atl(atl), .up_en(up_en), .up_ch(up_ch),
        .up_data(up_data), .in_valid(in_valid), .in_ch(in_ch), .pcm_in(pcm_in),
        .out_valid(ov2), .out_ch(oc2), .lr(lr2), .pcm_att(pa2));

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [CW-1:0] ch, input logic [7:0] d);
        up_en = 1'b1; up_ch = ch; up_data = d;
        tick();
        up_en = 1'b0;
    endtask

    task automatic send(input logic [CW-1:0] ch, input int pcm);
        in_valid = 1'b1; in_ch = ch; pcm_in = 16'(pcm);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run(input logic [CW-1:0] ch, input int pcm);
        send(ch, pcm);
        tick();
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1; cen = 1'b1; up_en = 1'b0; up_ch = '0; up_data = '0;
        in_valid = 1'b0; in_ch = '0; pcm_in = '0; atl = 6'd63;
        do_reset();
        chk("rst_valid", ov0, 0);
        chk("rst_ch", oc0, 0);
        chk("rst_lr", lr0, 0);
        chk("rst_pcm", pa0, 0);

        wr(0, 8'hDF);
        wr(1, 8'hDF);
        for (int n = 1; n <= 63; n++) begin
            run(0, 1000);
            chk("ramp_low", pa2, 0);
            chk("ramp_valid", ov2, 1);
            if (n == 10) begin
                run(1, 1000);
                chk("ramp_ch1", pa2, 0);
                chk("ramp_ch1_tag", oc2, 1);
            end
        end
        run(0, 1000);
        chk("ramp_64", pa2, 28);
        tick();
        chk("valid_drop", ov2, 0);
        cen = 1'b0; in_valid = 1'b1; in_ch = 0; pcm_in = 16'sd1000;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("cen_hold", ov2, 0);
        end
        in_valid = 1'b0; cen = 1'b1;
        run(0, 1000);
        chk("ramp_65", pa2, 32);

        do_reset();
        wr(2, 8'hDF);
        atl = 6'd63;
        run(2, 1000);
        chk("m0_db0_valid", ov0, 1);
        chk("m0_db0_ch", oc0, 2);
        chk("m0_db0_lr", lr0, 3);
        chk("m0_db0_pos", pa0, 7500);
        chk("m1_db0_pos", pa1, 1872);
        run(2, -1000);
        chk("m0_db0_neg", pa0, -7500);
        chk("m1_db0_neg", pa1, -1876);
        run(2, 20000);
        chk("m1_sat_pos", pa1, 32764);
        run(2, -20000);
        chk("m1_sat_neg", pa1, -32768);
        atl = 6'd55;
        run(2, 1000);
        chk("m0_db8", pa0, 3748);
        chk("m1_db8", pa1, 936);
        atl = 6'd0;
        run(4, 1000);
        chk("m0_db94", pa0, 0);
        chk("m0_db94_ch", oc0, 4);
        chk("m1_db94", pa1, 0);

        atl = 6'd63;
        send(2, 1000);
        send(2, -1000);
        send(4, 1000);
        tick();
        chk("b2b_0", pa0, 7500);
        chk("b2b_0_valid", ov0, 1);
        tick();
        chk("b2b_1", pa0, -7500);
        tick();
        chk("b2b_2", pa0, 500);
        chk("b2b_2_ch", oc0, 4);
        tick();
        chk("b2b_end", ov0, 0);

        up_en = 1'b1; up_ch = 3; up_data = 8'h9F;
        in_valid = 1'b1; in_ch = 3; pcm_in = 16'sd1000;
        tick();
        up_en = 1'b0; in_valid = 1'b0;
        tick(); tick(); tick();
        chk("wr_same_old", pa0, 500);
        chk("wr_same_lr", lr0, 0);
        run(3, 1000);
        chk("wr_new", pa0, 7500);
        chk("wr_new_lr", lr0, 2);
        wr(7, 8'h40);
        run(3, 1000);
        chk("wr_oob", pa0, 7500);
        chk("wr_oob_lr", lr0, 2);
        tick();
        run(6, 1000);
        chk("in_oob", ov0, 0);

        send(2, 1000);
        send(2, 1000);
        send(2, 1000);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("flush_valid", ov0, 0);
            chk("flush_pcm", pa0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
